// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   state_t          : arbiter FSM encoding (IDLE, ACCESS, ACK)
//   owner_t          : which port currently owns the memory (fetch or data)
//   MAX_WAIT_STATES  : largest supported number of wait states
//   cnt_width()      : width of the wait-state down-counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int MAX_WAIT_STATES = 15;

    // max(1, clog2(ws+1)): a zero-wait build still needs a 1-bit counter
    function automatic int cnt_width(input int ws);
        return (ws < 1) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way arbiter.
//   i_req0        : fetch port request
//   i_req1        : data port request
//   i_last_owner  : port granted most recently
//   i_fixed_prio  : 1 = data port wins every conflict, 0 = alternate
//   o_valid       : at least one request present
//   o_grant       : winning port (meaningful only when o_valid)
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   i_req0,
    input  logic   i_req1,
    input  owner_t i_last_owner,
    input  logic   i_fixed_prio,
    output logic   o_valid,
    output owner_t o_grant
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = OWN_IF;
        if (i_req0 && i_req1) begin
            if (i_fixed_prio)
                o_grant = OWN_D;
            else
                o_grant = (i_last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (i_req1) begin
            o_grant = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one unified memory between the instruction-fetch port and the
// data (load/store) port. Each access is granted in IDLE, held on the
// memory for WAIT_STATES extra cycles in ACCESS, and acknowledged with a
// one-cycle pulse in ACK.
//   clk, reset_n                 : clock, synchronous active-low reset
//   if_req/if_addr               : fetch request (level) and byte address
//   if_ack/if_rdata              : fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata    : data request, store flag, address, data
//   d_ack/d_rdata                : data completion pulse and loaded word
//   mem_addr/mem_wdata/mem_we    : drive the memory
//   mem_rdata                    : memory combinational read data
//   busy                         : high whenever the FSM is not IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int FIXED_PRIO  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int WS_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
    localparam int CNT_W  = cnt_width(WS_EFF);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WS_EFF);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    owner_t            r_owner;
    owner_t            r_last_owner;
    logic              r_we;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_d_rdata;

    logic              w_grant_valid;
    owner_t            w_grant;
    logic              w_if_ack;
    logic              w_d_ack;
    logic              w_mem_we;
    logic              w_capture;

    rr_arbiter2 u_pick (
        .i_req0       (if_req),
        .i_req1       (d_req),
        .i_last_owner (r_last_owner),
        .i_fixed_prio (FIXED_PRIO != 0),
        .o_valid      (w_grant_valid),
        .o_grant      (w_grant)
    );

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_if_ack     = 1'b0;
        w_d_ack      = 1'b0;
        w_mem_we     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ACCESS;
                    w_count_next = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (r_count != '0) begin
                    w_count_next = r_count - CNT_W'(1);
                end else begin
                    // Final ACCESS cycle: the write strobe and read capture
                    // both happen here, exactly once per access.
                    w_mem_we     = r_we;
                    w_capture    = ~r_we;
                    w_state_next = ACK;
                end
            end
            ACK: begin
                w_if_ack     = (r_owner == OWN_IF);
                w_d_ack      = (r_owner == OWN_D);
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_D;   // first conflict goes to fetch
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (r_state == IDLE && w_grant_valid) begin
                r_owner      <= w_grant;
                r_last_owner <= w_grant;
                if (w_grant == OWN_D) begin
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                    r_we        <= d_we;
                end else begin
                    // Fetches never write; mem_wdata keeps its last value.
                    r_mem_addr  <= if_addr;
                    r_we        <= 1'b0;
                end
            end
            if (w_capture) begin
                if (r_owner == OWN_IF)
                    r_if_rdata <= mem_rdata;
                else
                    r_d_rdata  <= mem_rdata;
            end
        end
    end

    assign if_ack    = w_if_ack;
    assign d_ack     = w_d_ack;
    assign mem_we    = w_mem_we;
    assign busy      = (r_state != IDLE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int WS_A = 1;
    localparam int FP_A = 0;
    localparam int WS_B = 0;
    localparam int FP_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_n;
    logic        sel;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic        a_if_ack, a_d_ack, a_mem_we, a_busy;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic        b_if_ack, b_d_ack, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h8C220004 : (32'hA000_0000 ^ (i * 32'h0001_0203));
    endfunction

    // physical memory seen by both arbiters
    bit [31:0] phys [256];
    bit        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) phys[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (a_mem_we) phys[a_mem_addr[9:2]] <= a_mem_wdata;
            if (b_mem_we) phys[b_mem_addr[9:2]] <= b_mem_wdata;
        end
    end
    wire [31:0] a_mem_rdata = phys[a_mem_addr[9:2]];
    wire [31:0] b_mem_rdata = phys[b_mem_addr[9:2]];

    mem_arbiter #(.WAIT_STATES(WS_A), .FIXED_PRIO(FP_A)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req & ~sel), .if_addr(if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .d_req(d_req & ~sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.WAIT_STATES(WS_B), .FIXED_PRIO(FP_B)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req & sel), .if_addr(if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(d_req & sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // observed outputs of the instance under test
    wire        s_if_ack    = sel ? b_if_ack    : a_if_ack;
    wire        s_d_ack     = sel ? b_d_ack     : a_d_ack;
    wire        s_mem_we    = sel ? b_mem_we    : a_mem_we;
    wire        s_busy      = sel ? b_busy      : a_busy;
    wire [31:0] s_if_rdata  = sel ? b_if_rdata  : a_if_rdata;
    wire [31:0] s_d_rdata   = sel ? b_d_rdata   : a_d_rdata;
    wire [31:0] s_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    wire [31:0] s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

    // reference model: memory image, last owner and held read data per instance
    logic [31:0] ref_mem [256];
    bit          m_last [2];
    logic [31:0] m_ird [2];
    logic [31:0] m_drd [2];
    int          ack_cyc [$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last[i] = 1'b1;
            m_ird[i]  = '0;
            m_drd[i]  = '0;
        end
    endtask

    // Entered at a negedge with the selected instance IDLE; serves the
    // winner and then the loser (if both request). Returns at the negedge
    // of the IDLE cycle after the last ACK, with requests dropped.
    task automatic run(input bit ir, input logic [31:0] ia, input bit dr,
                       input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
        int ws;
        bit fp;
        bit first;
        int n;
        ws = sel ? WS_B : WS_A;
        fp = sel ? (FP_B != 0) : (FP_A != 0);
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        chk("idle_busy", {31'd0, s_busy}, 32'd0);
        if (ir && dr) first = fp ? 1'b1 : ~m_last[sel];
        else          first = dr;
        n = (ir && dr) ? 2 : 1;
        for (int g = 0; g < n; g++) begin
            bit          own;
            bit          st;
            logic [31:0] ea;
            own = (g == 0) ? first : ~first;
            m_last[sel] = own;
            st = own & dwe;
            ea = own ? da : ia;
            for (int c = 1; c <= ws + 2; c++) begin
                @(negedge clk);
                chk("busy", {31'd0, s_busy}, 32'd1);
                chk("mem_addr", s_mem_addr, ea);
                if (st) chk("mem_wdata", s_mem_wdata, dwd);
                chk("mem_we", {31'd0, s_mem_we}, {31'd0, (st && c == ws + 1)});
                chk("if_ack", {31'd0, s_if_ack}, {31'd0, (!own && c == ws + 2)});
                chk("d_ack", {31'd0, s_d_ack}, {31'd0, (own && c == ws + 2)});
            end
            if (st) begin
                ref_mem[ea[9:2]] = dwd;
                chk("store_keeps_d_rdata", s_d_rdata, m_drd[sel]);
            end else if (own) begin
                m_drd[sel] = ref_mem[ea[9:2]];
                chk("d_rdata", s_d_rdata, m_drd[sel]);
            end else begin
                m_ird[sel] = ref_mem[ea[9:2]];
                chk("if_rdata", s_if_rdata, m_ird[sel]);
            end
            ack_cyc.push_back(cyc);
            $display("txn dut=%0d port=%s we=%0d addr=%h data=%h cyc=%0d",
                     sel, own ? "D " : "IF", st, ea, st ? dwd : ref_mem[ea[9:2]], cyc);
            if (own) d_req = 1'b0; else if_req = 1'b0;
            @(negedge clk);
            chk("busy_after_ack", {31'd0, s_busy}, 32'd0);
        end
    endtask

    initial begin
        int got;
        logic [31:0] old;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();
        sel = 1'b0; reset_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        @(negedge clk); @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            chk("rst_busy", {31'd0, s_busy}, 32'd0);
            chk("rst_if_ack", {31'd0, s_if_ack}, 32'd0);
            chk("rst_d_ack", {31'd0, s_d_ack}, 32'd0);
            chk("rst_mem_we", {31'd0, s_mem_we}, 32'd0);
            chk("rst_mem_addr", s_mem_addr, 32'd0);
            chk("rst_mem_wdata", s_mem_wdata, 32'd0);
            chk("rst_if_rdata", s_if_rdata, 32'd0);
            chk("rst_d_rdata", s_d_rdata, 32'd0);
        end
        sel = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        // fetch-only read
        run(1, 32'h10, 0, 0, 32'h0, 32'h0);
        chk("fetch_word", s_if_rdata, 32'h8C220004);

        // store then load
        run(0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF);
        run(0, 32'h0, 1, 0, 32'h20, 32'h0);
        chk("load_back", s_d_rdata, 32'hDEADBEEF);

        // round-robin conflict from reset: IF, D, IF, D, acks 4 apart
        reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; model_reset();
        @(negedge clk);
        ack_cyc.delete();
        run(1, 32'h44, 1, 0, 32'h88, 32'h0);
        run(1, 32'h48, 1, 0, 32'h8C, 32'h0);
        for (int i = 0; i < 3; i++) chk("rr_ack_spacing", ack_cyc[i+1] - ack_cyc[i], 32'd4);

        // reset in the middle of a store
        old = ref_mem[12];
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h12345678;
        @(negedge clk);
        chk("abort_busy_before", {31'd0, s_busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; d_req = 1'b0; model_reset();
        chk("abort_busy", {31'd0, s_busy}, 32'd0);
        chk("abort_mem_addr", s_mem_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_mem_we", {31'd0, s_mem_we}, 32'd0);
            chk("abort_d_ack", {31'd0, s_d_ack}, 32'd0);
            @(negedge clk);
        end
        run(0, 32'h0, 1, 0, 32'h30, 32'h0);
        chk("abort_word_kept", s_d_rdata, old);

        // randomized traffic on instance A
        for (int i = 0; i < 40; i++) begin
            bit ir, dr;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            run(ir, $urandom, dr, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        // instance B: zero wait states, back-to-back fetches, 3 cycles apart
        sel = 1'b1;
        @(negedge clk);
        ack_cyc.delete();
        run(1, 32'h0, 0, 0, 32'h0, 32'h0);
        run(1, 32'h4, 0, 0, 32'h0, 32'h0);
        chk("ws0_ack_spacing", ack_cyc[1] - ack_cyc[0], 32'd3);

        // instance B: fixed priority, data port keeps re-requesting
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        got = 0;
        for (int k = 0; k < 20 && got < 3; k++) begin
            @(negedge clk);
            chk("fp_no_if_ack", {31'd0, s_if_ack}, 32'd0);
            if (s_d_ack) begin
                chk("fp_d_rdata", s_d_rdata, ref_mem[d_addr[9:2]]);
                m_drd[1] = ref_mem[d_addr[9:2]];
                got++;
                d_addr = d_addr + 32'd4;
            end
        end
        chk("fp_grants", got, 32'd3);
        d_req = 1'b0;
        got = 0;
        for (int k = 0; k < 6 && got == 0; k++) begin
            @(negedge clk);
            if (s_if_ack) got = 1;
        end
        chk("fp_if_served", got, 32'd1);
        chk("fp_if_rdata", s_if_rdata, ref_mem[2]);
        m_ird[1] = ref_mem[2]; m_last[1] = 1'b0;
        if_req = 1'b0;
        @(negedge clk);

        // randomized traffic on instance B
        for (int i = 0; i < 20; i++) begin
            bit ir, dr;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) dr = 1'b1;
            run(ir, $urandom, dr, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        // final memory image against the model
        for (int i = 0; i < 256; i++) chk("mem_image", phys[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
